// File: rtl/fp_addsub_result_stage.sv
// Two-entry result buffer behind the FP add/sub datapath: flushes subnormals, zeroes exceptions.
// Optional macro FP_RESULT_EXC_COUNT_EN enables the saturating delivered-exception counter.
module fp_addsub_result_stage #(
    parameter bit FTZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_exception,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_exception,
    output logic        out_zero,
    output logic [7:0]  exc_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [31:0] r_res [2];
    logic        r_exc [2];

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_cap;

    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    assign out_result    = r_res[r_rd_ptr];
    assign out_exception = r_exc[r_rd_ptr];
    assign out_zero      = ~|r_res[r_rd_ptr][30:0];

    always_comb begin
        w_cap = in_result;
        if (in_exception) begin
            w_cap = 32'h0000_0000;
        end else if (FTZ && (in_result[30:23] == 8'h00)) begin
            w_cap = {in_result[31], 31'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_res[0] <= 32'h0000_0000;
            r_res[1] <= 32'h0000_0000;
            r_exc[0] <= 1'b0;
            r_exc[1] <= 1'b0;
        end else begin
            if (w_push) begin
                r_res[r_wr_ptr] <= w_cap;
                r_exc[r_wr_ptr] <= in_exception;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case (r_state)
                EMPTY: if (w_push) r_state <= ONE;
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_state <= FULL;
                    end else if (w_pop && !w_push) begin
                        r_state <= EMPTY;
                    end
                end
                FULL:    if (w_pop) r_state <= ONE;
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef FP_RESULT_EXC_COUNT_EN
    logic [7:0] r_exc_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exc_cnt <= 8'h00;
        end else if (w_pop && out_exception && (r_exc_cnt != 8'hFF)) begin
            r_exc_cnt <= r_exc_cnt + 8'h01;
        end
    end

    assign exc_count = r_exc_cnt;
`else
    assign exc_count = 8'h00;
`endif

endmodule

// File: tb/tb_fp_addsub_result_stage.sv
// Directed bench for fp_addsub_result_stage; runs FTZ=1 and FTZ=0 instances side by side.
module tb_fp_addsub_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_exception;
    logic        out_ready;

    logic        in_ready,  in_ready0;
    logic        out_valid, out_valid0;
    logic [31:0] out_result, out_result0;
    logic        out_exception, out_exception0;
    logic        out_zero, out_zero0;
    logic [7:0]  exc_count, exc_count0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fp_addsub_result_stage #(.FTZ(1'b1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_exception(in_exception),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exception(out_exception),
        .out_zero(out_zero), .exc_count(exc_count)
    );

    fp_addsub_result_stage #(.FTZ(1'b0)) dut0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_result(in_result), .in_exception(in_exception),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_result(out_result0), .out_exception(out_exception0),
        .out_zero(out_zero0), .exc_count(exc_count0)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] ir;
        logic        ie;
        logic        ordy;
        logic        ov;
        logic        irdy;
        logic [31:0] res;
        logic        exc;
        logic        zero;
        logic [31:0] res0;
        logic        zero0;
    } vec_t;

    localparam int NV = 17;
    vec_t v [NV];

`ifdef FP_RESULT_EXC_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ir, input logic ie, input logic ordy);
        in_valid     = iv;
        in_result    = ir;
        in_exception = ie;
        out_ready    = ordy;
    endtask

    initial begin
        // iv, in_result, ie, ordy | ov, irdy, res, exc, zero, res(FTZ=0), zero(FTZ=0)
        v[0]  = '{1'b1, 32'h4040_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 32'h4040_0000, 1'b0};
        v[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        v[2]  = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0};
        v[3]  = '{1'b1, 32'h4000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0};
        v[4]  = '{1'b1, 32'h4040_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0};
        v[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b0};
        v[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        v[7]  = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h3F80_0000, 1'b0};
        v[8]  = '{1'b1, 32'hC0A0_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'hC0A0_0000, 1'b0, 1'b0, 32'hC0A0_0000, 1'b0};
        v[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        v[10] = '{1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0,         1'b1};
        v[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        v[12] = '{1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0001, 1'b0};
        v[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};
        v[14] = '{1'b1, 32'h0040_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0040_0000, 1'b0};
        v[15] = '{1'b1, 32'h7F80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h7F80_0000, 1'b0, 1'b0, 32'h7F80_0000, 1'b0};
        v[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 32'h0,         1'b1};

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();
        step();
        chk("rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_exception", {31'b0, out_exception}, 32'd0);
        chk("rst out_zero", {31'b0, out_zero}, 32'd1);
        chk("rst exc_count", {24'b0, exc_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(v[i].iv, v[i].ir, v[i].ie, v[i].ordy);
            step();
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, v[i].ov});
            chk($sformatf("v%0d in_ready", i), {31'b0, in_ready}, {31'b0, v[i].irdy});
            chk($sformatf("v%0d ftz0 out_valid", i), {31'b0, out_valid0}, {31'b0, v[i].ov});
            if (v[i].ov) begin
                chk($sformatf("v%0d out_result", i), out_result, v[i].res);
                chk($sformatf("v%0d out_exception", i), {31'b0, out_exception}, {31'b0, v[i].exc});
                chk($sformatf("v%0d out_zero", i), {31'b0, out_zero}, {31'b0, v[i].zero});
                chk($sformatf("v%0d ftz0 out_result", i), out_result0, v[i].res0);
                chk($sformatf("v%0d ftz0 out_zero", i), {31'b0, out_zero0}, {31'b0, v[i].zero0});
            end
        end
        chk("exc_count after table", {24'b0, exc_count}, CNT_EN ? 32'd1 : 32'd0);

        // Fill with exception entries, then reset while the head is being popped.
        drive(1'b1, 32'h7F80_0000, 1'b1, 1'b0);
        step();
        step();
        chk("full in_ready", {31'b0, in_ready}, 32'd0);
        chk("full out_valid", {31'b0, out_valid}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst out_result", out_result, 32'd0);
        chk("midrst out_zero", {31'b0, out_zero}, 32'd1);
        chk("midrst exc_count", {24'b0, exc_count}, 32'd0);
        step();
        chk("post-rst out_valid", {31'b0, out_valid}, 32'd0);
        chk("post-rst exc_count", {24'b0, exc_count}, 32'd0);

        // Streaming exceptions: one push and one pop per cycle after the first.
        drive(1'b1, 32'h7F80_0000, 1'b1, 1'b1);
        for (int k = 0; k < 300; k++) begin
            step();
            chk($sformatf("sat%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("sat%0d out_result", k), out_result, 32'd0);
            chk($sformatf("sat%0d out_exception", k), {31'b0, out_exception}, 32'd1);
            chk($sformatf("sat%0d exc_count", k), {24'b0, exc_count},
                CNT_EN ? ((k > 255) ? 32'd255 : k) : 32'd0);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step();
        step();
        chk("sat drained out_valid", {31'b0, out_valid}, 32'd0);
        chk("sat final exc_count", {24'b0, exc_count}, CNT_EN ? 32'd255 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
